// File: rtl/riodrive_bus_sched_pkg.sv
// ---------------------------------------------------------------------------
// riodrive_sched_pkg
// Shared types and constants for the riodrive CAN bus scheduler slice:
//   - ID_W         : CAN arbitration ID width (standard 11-bit frames)
//   - TX_DLC/RX_DLC: payload length of command (4 byte) and status (8 byte) frames
//   - sched_state_e: scheduler FSM states
//   - byteSwap32   : converts a little-endian velocity word to CAN byte order
// ---------------------------------------------------------------------------
package riodrive_sched_pkg;

  localparam int ID_W = 11;

  localparam logic [3:0] TX_DLC = 4'd4;
  localparam logic [3:0] RX_DLC = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ACCEPT,
    DONE
  } sched_state_e;

  // The drive expects the least significant velocity byte first on the wire,
  // so byte 0 of the word ends up in the top byte of tx_data.
  function automatic logic [31:0] byteSwap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/riodrive_bus_sched_if.sv
// ---------------------------------------------------------------------------
// riodrive_bus_sched_if
// Bundles the signals between the scheduler and the shared canbus_tx /
// canbus_rx instances.
//   master : scheduler side (drives tx_start/tx_arib/tx_dlc/tx_data,
//            observes tx_busy and the received-frame strobe)
//   slave  : CAN PHY side (the opposite directions)
// Signals:
//   tx_start  1-clock start pulse to canbus_tx
//   tx_arib   11-bit arbitration ID of the outgoing frame
//   tx_dlc    outgoing DLC
//   tx_data   outgoing 4-byte payload
//   tx_busy   canbus_tx busy flag
//   rx_valid  canbus_rx frame-valid pulse
//   rx_arib   received arbitration ID
//   rx_dlc    received DLC
// ---------------------------------------------------------------------------
interface riodrive_bus_sched_if;
  import riodrive_sched_pkg::*;

  logic            tx_start;
  logic [ID_W-1:0] tx_arib;
  logic [3:0]      tx_dlc;
  logic [31:0]     tx_data;
  logic            tx_busy;
  logic            rx_valid;
  logic [ID_W-1:0] rx_arib;
  logic [3:0]      rx_dlc;

  modport master (
    output tx_start, tx_arib, tx_dlc, tx_data,
    input  tx_busy, rx_valid, rx_arib, rx_dlc
  );

  modport slave (
    input  tx_start, tx_arib, tx_dlc, tx_data,
    output tx_busy, rx_valid, rx_arib, rx_dlc
  );

endinterface

// File: rtl/riodrive_bus_sched_wdog.sv
// ---------------------------------------------------------------------------
// riodrive_sched_wdog
// Response watchdog for a single drive axis. Every status hit reloads a
// down-counter to TIMEOUT and clears the error flag; when the counter runs
// out the error flag is raised and held until the next hit. The counter
// saturates at zero. The error flag starts set because no status frame has
// been seen after reset.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   hit_i  one-clock pulse: a status frame arrived for this axis
//   err_o  level: axis has not answered within TIMEOUT clocks
// ---------------------------------------------------------------------------
module riodrive_sched_wdog #(
  parameter int TIMEOUT = 15000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit_i,
  output logic err_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  // Next-state logic: a hit always wins over the countdown; the flag is
  // raised on the step that takes the counter from 1 to 0.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (hit_i) begin
      cnt_d = W'(TIMEOUT);
      err_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
      if (cnt_q == W'(1)) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/riodrive_bus_sched.sv
// ---------------------------------------------------------------------------
// riodrive_bus_sched
// Shares one CAN bus between AXES riodrive motor nodes. Each scheduling cycle
// (started every PERIOD clocks or by sync_i) sends one 4-byte velocity frame
// per axis in ascending axis order, then goes idle. Incoming 8-byte status
// frames are demultiplexed to a one-hot per-axis hit pulse.
// Optional feature: define RIODRIVE_SCHED_WDOG_EN to add a per-axis response
// watchdog (rx_err_o); without it rx_err_o is tied to 0.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   bus         riodrive_bus_sched_if.master (canbus_tx / canbus_rx side)
//   sync_i      1-clock pulse: start a cycle now and reload the period counter
//   enable_i    per-axis enable; a disabled axis is sent with velocity 0
//   velocity_i  axis i velocity in bits [32i+31:32i]
//   rx_hit_o    one-hot 1-clock pulse: status frame belongs to axis i
//   rx_err_o    per-axis watchdog error level
//   overrun_o   1-clock pulse: a trigger was dropped during an active cycle
//   active_o    high while a scheduling cycle is in progress
// ---------------------------------------------------------------------------
module riodrive_bus_sched
  import riodrive_sched_pkg::*;
#(
  parameter int              AXES       = 4,
  parameter int              PERIOD     = 5000,
  parameter logic [ID_W-1:0] TX_BASE_ID = 11'h00D,
  parameter logic [ID_W-1:0] RX_BASE_ID = 11'h01E,
  parameter logic [ID_W-1:0] ID_STRIDE  = 11'h020,
  parameter int              TIMEOUT    = 15000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  riodrive_bus_sched_if.master   bus,
  input  logic                   sync_i,
  input  logic [AXES-1:0]        enable_i,
  input  logic [32*AXES-1:0]     velocity_i,
  output logic [AXES-1:0]        rx_hit_o,
  output logic [AXES-1:0]        rx_err_o,
  output logic                   overrun_o,
  output logic                   active_o
);

  localparam int IDX_W = (AXES > 1) ? $clog2(AXES) : 1;
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(AXES - 1);

  sched_state_e     state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_start_q;
  logic [ID_W-1:0]  tx_arib_q, tx_arib_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic             overrun_q;
  logic             active_q;
  logic [AXES-1:0]  rx_hit_q, rx_hit_d;
  logic             trigger;

  // A sync pulse and an expiring period counter coincide into one trigger;
  // either reloads the counter in the same clock.
  assign trigger = sync_i | (cnt_q == '0);

  // Period counter next value.
  always_comb begin
    cnt_d = trigger ? CNT_RELOAD : (cnt_q - CNT_W'(1));
  end

  // Frame for the current axis, captured when the FSM leaves LOAD.
  always_comb begin
    tx_arib_d = TX_BASE_ID + ID_W'(idx_q) * ID_STRIDE;
    tx_data_d = enable_i[idx_q] ? byteSwap32(velocity_i[32*idx_q +: 32]) : '0;
  end

  // Scheduler FSM with registered outputs. tx_start defaults low so it is
  // high for exactly the clock spent in START. A trigger arriving while a
  // cycle is active only raises overrun; the running cycle is not touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= CNT_RELOAD;
      tx_start_q <= 1'b0;
      tx_arib_q  <= '0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overrun_q  <= trigger & active_q;
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            idx_q    <= '0;
            active_q <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          tx_arib_q  <= tx_arib_d;
          tx_data_q  <= tx_data_d;
          tx_start_q <= 1'b1;
          state_q    <= START;
        end
        START: begin
          state_q <= ACCEPT;
        end
        ACCEPT: begin
          if (bus.tx_busy) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!bus.tx_busy) begin
            if (idx_q == IDX_LAST) begin
              active_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= LOAD;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status frame decode: only 8-byte frames on an axis status ID count.
  always_comb begin
    rx_hit_d = '0;
    for (int i = 0; i < AXES; i++) begin
      rx_hit_d[i] = bus.rx_valid && (bus.rx_dlc == RX_DLC) &&
                    (bus.rx_arib == RX_BASE_ID + ID_W'(i) * ID_STRIDE);
    end
  end

  // Registered status hit, one clock after rx_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hit_q <= '0;
    end else begin
      rx_hit_q <= rx_hit_d;
    end
  end

`ifdef RIODRIVE_SCHED_WDOG_EN
  for (genvar g = 0; g < AXES; g++) begin : gWdog
    riodrive_sched_wdog #(
      .TIMEOUT(TIMEOUT)
    ) uWdog (
      .clk   (clk),
      .rst_n (rst_n),
      .hit_i (rx_hit_q[g]),
      .err_o (rx_err_o[g])
    );
  end
`else
  assign rx_err_o = '0;
`endif

  assign bus.tx_start = tx_start_q;
  assign bus.tx_arib  = tx_arib_q;
  assign bus.tx_dlc   = TX_DLC;
  assign bus.tx_data  = tx_data_q;
  assign rx_hit_o     = rx_hit_q;
  assign overrun_o    = overrun_q;
  assign active_o     = active_q;

endmodule
